// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin two-master AXI read arbiter, one outstanding burst, gnt-routed R channel
module axi_read_arbiter #(
  parameter int ID_M_W = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_M_W-1:0]   ARID_M0,
  input  logic [ADDR_W-1:0]   ARADDR_M0,
  input  logic [LEN_W-1:0]    ARLEN_M0,
  input  logic [2:0]          ARSIZE_M0,
  input  logic [1:0]          ARBURST_M0,
  input  logic                ARVALID_M0,
  output logic                ARREADY_M0,
  output logic [ID_M_W-1:0]   RID_M0,
  output logic [DATA_W-1:0]   RDATA_M0,
  output logic [1:0]          RRESP_M0,
  output logic                RLAST_M0,
  output logic                RVALID_M0,
  input  logic                RREADY_M0,
  input  logic [ID_M_W-1:0]   ARID_M1,
  input  logic [ADDR_W-1:0]   ARADDR_M1,
  input  logic [LEN_W-1:0]    ARLEN_M1,
  input  logic [2:0]          ARSIZE_M1,
  input  logic [1:0]          ARBURST_M1,
  input  logic                ARVALID_M1,
  output logic                ARREADY_M1,
  output logic [ID_M_W-1:0]   RID_M1,
  output logic [DATA_W-1:0]   RDATA_M1,
  output logic [1:0]          RRESP_M1,
  output logic                RLAST_M1,
  output logic                RVALID_M1,
  input  logic                RREADY_M1,
  output logic [2*ID_M_W-1:0] ARID_S,
  output logic [ADDR_W-1:0]   ARADDR_S,
  output logic [LEN_W-1:0]    ARLEN_S,
  output logic [2:0]          ARSIZE_S,
  output logic [1:0]          ARBURST_S,
  output logic                ARVALID_S,
  input  logic                ARREADY_S,
  input  logic [2*ID_M_W-1:0] RID_S,
  input  logic [DATA_W-1:0]   RDATA_S,
  input  logic [1:0]          RRESP_S,
  input  logic                RLAST_S,
  input  logic                RVALID_S,
  output logic                RREADY_S,
  output logic                BUSY
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state_q, state_d;
  logic gnt_q, gnt_d, prio_q, prio_d;
  logic in_addr, in_data;
  assign in_addr = state_q == ADDR;
  assign in_data = state_q == DATA;
  assign BUSY = state_q != IDLE;
  // AR fields follow gnt in every state; only the valid/ready qualifiers depend on state
  assign ARID_S    = {{(ID_M_W-1){1'b0}}, gnt_q, gnt_q ? ARID_M1 : ARID_M0};
  assign ARADDR_S  = gnt_q ? ARADDR_M1 : ARADDR_M0;
  assign ARLEN_S   = gnt_q ? ARLEN_M1 : ARLEN_M0;
  assign ARSIZE_S  = gnt_q ? ARSIZE_M1 : ARSIZE_M0;
  assign ARBURST_S = gnt_q ? ARBURST_M1 : ARBURST_M0;
  assign ARVALID_S  = in_addr & (gnt_q ? ARVALID_M1 : ARVALID_M0);
  assign ARREADY_M0 = in_addr & ~gnt_q & ARREADY_S;
  assign ARREADY_M1 = in_addr & gnt_q & ARREADY_S;
  assign RVALID_M0 = in_data & ~gnt_q & RVALID_S;
  assign RVALID_M1 = in_data & gnt_q & RVALID_S;
  assign RREADY_S  = in_data & (gnt_q ? RREADY_M1 : RREADY_M0);
  assign RID_M0   = RID_S[ID_M_W-1:0];
  assign RID_M1   = RID_S[ID_M_W-1:0];
  assign RDATA_M0 = RDATA_S;
  assign RDATA_M1 = RDATA_S;
  assign RRESP_M0 = RRESP_S;
  assign RRESP_M1 = RRESP_S;
  assign RLAST_M0 = RLAST_S;
  assign RLAST_M1 = RLAST_S;
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: if (ARVALID_M0 | ARVALID_M1) begin
        gnt_d   = (ARVALID_M0 & ARVALID_M1) ? prio_q : ARVALID_M1;
        state_d = ADDR;
      end
      ADDR: if (ARVALID_S & ARREADY_S) state_d = DATA;
      DATA: if (RVALID_S & RREADY_S & RLAST_S) begin
        state_d = IDLE;
        prio_d  = ~gnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
    end
  end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed self-checking bench for axi_read_arbiter
module tb_axi_read_arbiter;
  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  ARID_M0, ARID_M1, RID_M0, RID_M1, ARLEN_M0, ARLEN_M1, ARLEN_S;
  logic [31:0] ARADDR_M0, ARADDR_M1, ARADDR_S, RDATA_M0, RDATA_M1, RDATA_S;
  logic [2:0]  ARSIZE_M0, ARSIZE_M1, ARSIZE_S;
  logic [1:0]  ARBURST_M0, ARBURST_M1, ARBURST_S, RRESP_M0, RRESP_M1, RRESP_S;
  logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1, ARVALID_S, ARREADY_S;
  logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
  logic [7:0]  ARID_S, RID_S;
  logic        RLAST_S, RVALID_S, RREADY_S, BUSY;
  int n_chk = 0, n_err = 0;
  axi_read_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
    .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .BUSY(BUSY)
  );
  always #5 ACLK = ~ACLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask
  task automatic clear_inputs();
    {ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0, ARVALID_M0, RREADY_M0} = '0;
    {ARID_M1, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1, ARVALID_M1, RREADY_M1} = '0;
    {ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S} = '0;
  endtask
  task automatic do_reset();
    ARESETn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge ACLK);
    #3 ARESETn = 1'b1;
    tick();
  endtask
  // Caller leaves a request pending in IDLE; this walks it through ADDR (with stalls) and one DATA beat
  task automatic serve(input string tag, input int stall, input logic [7:0] arid,
                       input logic [31:0] addr, input logic [31:0] d, input logic [1:0] rsp);
    logic g;
    g = arid[4];
    tick();
    ARREADY_S = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #1;
      chk({tag, "_stall_arv"}, ARVALID_S, 1);
      chk({tag, "_stall_addr"}, ARADDR_S, addr);
      chk({tag, "_stall_arrdy"}, {ARREADY_M1, ARREADY_M0}, 0);
      tick();
    end
    ARREADY_S = 1'b1;
    #1;
    chk({tag, "_arv"}, ARVALID_S, 1);
    chk({tag, "_arid"}, ARID_S, arid);
    chk({tag, "_addr"}, ARADDR_S, addr);
    chk({tag, "_arrdy"}, {ARREADY_M1, ARREADY_M0}, g ? 2 : 1);
    chk({tag, "_busy"}, BUSY, 1);
    tick();
    ARREADY_S = 1'b0;
    if (g) ARVALID_M1 = 1'b0; else ARVALID_M0 = 1'b0;
    RVALID_S = 1'b1; RLAST_S = 1'b1; RDATA_S = d; RRESP_S = rsp; RID_S = {4'hF, arid[3:0]};
    RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
    #1;
    chk({tag, "_arv_data"}, ARVALID_S, 0);
    chk({tag, "_rvalid"}, {RVALID_M1, RVALID_M0}, g ? 2 : 1);
    chk({tag, "_rdata"}, g ? RDATA_M1 : RDATA_M0, d);
    chk({tag, "_rid"}, g ? RID_M1 : RID_M0, arid[3:0]);
    chk({tag, "_rresp"}, g ? RRESP_M1 : RRESP_M0, rsp);
    chk({tag, "_rready_s"}, RREADY_S, 1);
    tick();
    {RVALID_S, RLAST_S, RREADY_M0, RREADY_M1} = '0;
    #1;
    chk({tag, "_idle"}, BUSY, 0);
  endtask
  initial begin
    int b;
    ARESETn = 1'b0;
    clear_inputs();
    #2;
    chk("rst_busy", BUSY, 0);
    chk("rst_arv", ARVALID_S, 0);
    chk("rst_arrdy", {ARREADY_M1, ARREADY_M0}, 0);
    chk("rst_rv", {RVALID_M1, RVALID_M0}, 0);
    chk("rst_rready", RREADY_S, 0);
    chk("rst_arid", ARID_S, 0);
    do_reset();
    ARID_M0 = 4'h3; ARADDR_M0 = 32'h40; ARVALID_M0 = 1'b1;
    #1;
    chk("m0_idle_arv", ARVALID_S, 0);
    serve("m0", 0, 8'h03, 32'h40, 32'hDEAD_BEEF, 2'b00);
    do_reset();
    ARID_M0 = 4'h1; ARADDR_M0 = 32'h100; ARID_M1 = 4'h2; ARADDR_M1 = 32'h200;
    ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1;
    serve("both1_m0", 0, 8'h01, 32'h100, 32'h1111_0000, 2'b00);
    serve("both1_m1", 0, 8'h12, 32'h200, 32'h2222_0000, 2'b00);
    ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1;
    serve("both2_m0", 0, 8'h01, 32'h100, 32'h3333_0000, 2'b00);
    serve("both2_m1", 0, 8'h12, 32'h200, 32'h4444_0000, 2'b00);
    ARID_M1 = 4'h7; ARADDR_M1 = 32'h300; ARLEN_M1 = 4'd3; ARVALID_M1 = 1'b1;
    tick();
    ARREADY_S = 1'b1;
    #1;
    chk("burst_arlen", ARLEN_S, 3);
    chk("burst_arid", ARID_S, 8'h17);
    tick();
    ARREADY_S = 1'b0; ARVALID_M1 = 1'b0; RVALID_S = 1'b1;
    b = 0;
    for (int k = 0; k < 8; k++) begin
      RREADY_M1 = k[0]; RDATA_S = 32'h1000 + b; RLAST_S = b == 3;
      #1;
      chk("burst_busy", BUSY, 1);
      chk("burst_rready_s", RREADY_S, k[0]);
      chk("burst_rv0", RVALID_M0, 0);
      if (k[0]) begin
        chk("burst_rdata", RDATA_M1, 32'h1000 + k / 2);
        b++;
      end
      tick();
    end
    {RVALID_S, RLAST_S, RREADY_M1} = '0;
    #1;
    chk("burst_done", BUSY, 0);
    ARID_M0 = 4'h5; ARADDR_M0 = 32'h80; ARVALID_M0 = 1'b1;
    serve("stall", 5, 8'h05, 32'h80, 32'h5555_AAAA, 2'b00);
    ARVALID_M0 = 1'b1;
    serve("err", 0, 8'h05, 32'h80, 32'hBAD0_BAD0, 2'b11);
    ARID_M1 = 4'h9; ARADDR_M1 = 32'h900; ARVALID_M1 = 1'b1;
    tick();
    ARREADY_S = 1'b1;
    tick();
    ARREADY_S = 1'b0; ARVALID_M1 = 1'b0; RVALID_S = 1'b1; RREADY_M1 = 1'b1;
    #1;
    chk("rstmid_busy_pre", BUSY, 1);
    chk("rstmid_rv_pre", RVALID_M1, 1);
    ARESETn = 1'b0;
    #1;
    chk("rstmid_busy", BUSY, 0);
    chk("rstmid_rv", {RVALID_M1, RVALID_M0}, 0);
    chk("rstmid_rready", RREADY_S, 0);
    chk("rstmid_arv", ARVALID_S, 0);
    do_reset();
    ARID_M0 = 4'hA; ARADDR_M0 = 32'hA00; ARID_M1 = 4'hB; ARADDR_M1 = 32'hB00;
    ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1;
    serve("post_rst_m0", 0, 8'h0A, 32'hA00, 32'h0A0A_0A0A, 2'b00);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
